c3aibadapt_avmm_usr32_rsp: RTL and testbench

Single-outstanding AVMM32 transaction tracker between the user-AVMM 8→32 expander and the 32-bit user register target. It registers each accepted 32-bit read/write, drives it to the target, holds target-side waitrequest, and returns byte-masked read data with a one-cycle `rdatavalid` pulse. A timeout watchdog terminates hung target transactions: reads return `ERR_DATA`, and a sticky error flag is set so the AVMM bus never deadlocks.

---
 rtl/c3aibadapt_avmm_usr32_rsp.sv | 126 ++++++++++++
 tb/tb_c3aibadapt_avmm_usr32_rsp.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/c3aibadapt_avmm_usr32_rsp.sv
// c3aibadapt_avmm_usr32_rsp: single-outstanding AVMM32 tracker with byte-masked read return and timeout watchdog.
module c3aibadapt_avmm_usr32_rsp #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        i_usr_avmm_clk,
  input  logic        i_usr_avmm_rst_n,
  input  logic        i_avmm32_read,
  input  logic        i_avmm32_write,
  input  logic [16:0] i_avmm32_addr,
  input  logic [31:0] i_avmm32_wdata,
  input  logic [3:0]  i_avmm32_byte_en,
  output logic [31:0] o_avmm32_rdata,
  output logic        o_avmm32_rdatavalid,
  output logic        o_avmm32_waitrequest,
  output logic        o_tgt_read,
  output logic        o_tgt_write,
  output logic [16:0] o_tgt_addr,
  output logic [31:0] o_tgt_wdata,
  output logic [3:0]  o_tgt_byte_en,
  input  logic [31:0] i_tgt_rdata,
  input  logic        i_tgt_rdatavalid,
  input  logic        i_tgt_waitrequest,
  input  logic        i_err_clr,
  output logic        o_timeout_err,
  output logic        o_drop_err
);
  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_e;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, mask;
  logic [3:0]  be_q, be_d;
  logic        is_rd_q, is_rd_d, tgt_rd_q, tgt_rd_d, tgt_wr_q, tgt_wr_d;
  logic        rdv_q, rdv_d, wait_q, wait_d, tout_q, tout_d, drop_q, drop_d;
  logic        req, tmo, force_end;
  always_comb begin
    mask      = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    req       = i_avmm32_read | i_avmm32_write;
    // Fires one cycle early so the forced result is registered when the counter reaches the limit.
    tmo       = cnt_q == 8'(TIMEOUT_CYC - 1);
    state_d   = state_q;
    cnt_d     = (state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    is_rd_d   = is_rd_q;
    tgt_rd_d  = tgt_rd_q;
    tgt_wr_d  = tgt_wr_q;
    rdv_d     = 1'b0;
    force_end = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d  = CMD;
        addr_d   = i_avmm32_addr;
        wdata_d  = i_avmm32_wdata;
        be_d     = i_avmm32_byte_en;
        is_rd_d  = i_avmm32_read;
        tgt_rd_d = i_avmm32_read;
        tgt_wr_d = ~i_avmm32_read;
      end
      CMD: if (!i_tgt_waitrequest) begin
        tgt_rd_d = 1'b0;
        tgt_wr_d = 1'b0;
        state_d  = (is_rd_q & ~i_tgt_rdatavalid) ? RDWAIT : IDLE;
        rdv_d    = is_rd_q & i_tgt_rdatavalid;
      end else force_end = tmo;
      RDWAIT: if (i_tgt_rdatavalid) begin
        rdv_d   = 1'b1;
        state_d = IDLE;
      end else force_end = tmo;
      default: state_d = IDLE;
    endcase
    if (force_end) begin
      tgt_rd_d = 1'b0;
      tgt_wr_d = 1'b0;
      state_d  = IDLE;
      rdv_d    = is_rd_q;
    end
    rdata_d = force_end ? (is_rd_q ? ERR_DATA & mask : rdata_q) : rdv_d ? i_tgt_rdata & mask : rdata_q;
    wait_d  = state_d != IDLE;
    tout_d  = force_end | (tout_q & ~i_err_clr);
    drop_d  = (req & (state_q != IDLE)) | (drop_q & ~i_err_clr);
  end
  always_ff @(posedge i_usr_avmm_clk or negedge i_usr_avmm_rst_n) begin
    if (!i_usr_avmm_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      is_rd_q  <= 1'b0;
      tgt_rd_q <= 1'b0;
      tgt_wr_q <= 1'b0;
      rdata_q  <= '0;
      rdv_q    <= 1'b0;
      wait_q   <= 1'b0;
      tout_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      is_rd_q  <= is_rd_d;
      tgt_rd_q <= tgt_rd_d;
      tgt_wr_q <= tgt_wr_d;
      rdata_q  <= rdata_d;
      rdv_q    <= rdv_d;
      wait_q   <= wait_d;
      tout_q   <= tout_d;
      drop_q   <= drop_d;
    end
  end
  assign o_avmm32_rdata       = rdata_q;
  assign o_avmm32_rdatavalid  = rdv_q;
  assign o_avmm32_waitrequest = wait_q;
  assign o_tgt_read           = tgt_rd_q;
  assign o_tgt_write          = tgt_wr_q;
  assign o_tgt_addr           = addr_q;
  assign o_tgt_wdata          = wdata_q;
  assign o_tgt_byte_en        = be_q;
  assign o_timeout_err        = tout_q;
  assign o_drop_err           = drop_q;
endmodule

// File: tb/tb_c3aibadapt_avmm_usr32_rsp.sv
// tb_c3aibadapt_avmm_usr32_rsp: randomized transaction-level check of the AVMM32 tracker against a latency/timeout model.
module tb_c3aibadapt_avmm_usr32_rsp;
  localparam int T = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rd_i = 1'b0, wr_i = 1'b0, tgt_rdv = 1'b0, tgt_wait = 1'b0, err_clr = 1'b0;
  logic [16:0] addr_i = '0;
  logic [31:0] wdata_i = '0, tgt_rdata = '0;
  logic [3:0]  be_i = '0;
  logic [31:0] rdata;
  logic        rdv, waitreq, tgt_rd, tgt_wr, tout_err, drop_err;
  logic [16:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_be;
  int nvec = 0, nerr = 0;
  c3aibadapt_avmm_usr32_rsp #(.TIMEOUT_CYC(T), .ERR_DATA(ERR)) dut (
    .i_usr_avmm_clk(clk), .i_usr_avmm_rst_n(rst_n),
    .i_avmm32_read(rd_i), .i_avmm32_write(wr_i), .i_avmm32_addr(addr_i),
    .i_avmm32_wdata(wdata_i), .i_avmm32_byte_en(be_i),
    .o_avmm32_rdata(rdata), .o_avmm32_rdatavalid(rdv), .o_avmm32_waitrequest(waitreq),
    .o_tgt_read(tgt_rd), .o_tgt_write(tgt_wr), .o_tgt_addr(tgt_addr),
    .o_tgt_wdata(tgt_wdata), .o_tgt_byte_en(tgt_be),
    .i_tgt_rdata(tgt_rdata), .i_tgt_rdatavalid(tgt_rdv), .i_tgt_waitrequest(tgt_wait),
    .i_err_clr(err_clr), .o_timeout_err(tout_err), .o_drop_err(drop_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction
  // acc_ok: target ever drops waitrequest (after w cycles); rsp_ok: read data returned d cycles after acceptance.
  task automatic run_txn(input bit rd, input bit wr, input logic [16:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int w, input int d, input bit acc_ok,
                         input bit rsp_ok, input bit drop, input logic [31:0] td);
    bit is_rd, ok;
    int kc, kdone, cmd_n, rdv_n, rdv_k, done;
    logic [31:0] got;
    is_rd = rd;
    kc    = is_rd ? w + d : w;
    ok    = acc_ok && (!is_rd || rsp_ok) && kc <= T - 1;
    kdone = ok ? kc + 1 : T;
    cmd_n = 0; rdv_n = 0; rdv_k = -1; done = -1; got = '0;
    @(negedge clk);
    chk("idle_wait", 32'(waitreq), 32'd0);
    rd_i = rd; wr_i = wr; addr_i = a; wdata_i = wd; be_i = be;
    for (int k = 0; k < T + 3; k++) begin
      @(negedge clk);
      rd_i = 1'b0;
      wr_i = drop && k == 0;
      if (k == 0) begin
        chk("cmd_rd", 32'(tgt_rd), 32'(is_rd));
        chk("cmd_wr", 32'(tgt_wr), 32'(!is_rd));
        chk("cmd_addr", 32'(tgt_addr), 32'(a));
        chk("cmd_wdata", tgt_wdata, wd);
        chk("cmd_be", 32'(tgt_be), 32'(be));
        chk("busy", 32'(waitreq), 32'd1);
      end
      if (tgt_rd || tgt_wr) cmd_n++;
      if (rdv) begin
        rdv_n++;
        rdv_k = k;
        got = rdata;
      end
      if (!waitreq && done < 0) done = k;
      tgt_wait  = !(acc_ok && k >= w);
      tgt_rdv   = (is_rd && acc_ok && rsp_ok && k == w + d) || k == kdone + 1;
      tgt_rdata = (k == w + d) ? td : $urandom;
    end
    @(negedge clk);
    tgt_wait = 1'b0; tgt_rdv = 1'b0; wr_i = 1'b0;
    chk("cmd_cycles", 32'(cmd_n), 32'(acc_ok ? w + 1 : T));
    chk("done_cycle", 32'(done), 32'(kdone));
    chk("rdv_count", 32'(rdv_n), 32'(is_rd));
    if (is_rd) begin
      chk("rdv_cycle", 32'(rdv_k), 32'(kdone));
      chk("rdata", got, (ok ? td : ERR) & bmask(be));
    end
    chk("timeout_err", 32'(tout_err), 32'(!ok));
    chk("drop_err", 32'(drop_err), 32'(drop));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_tout", 32'(tout_err), 32'd0);
    chk("clr_drop", 32'(drop_err), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_wait", 32'(waitreq), 32'd0);
    chk("rst_rdv", 32'(rdv), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_tgt", {tgt_rd, tgt_wr, tgt_be, tgt_addr}, 32'd0);
    chk("rst_err", {30'd0, tout_err, drop_err}, 32'd0);
    rst_n = 1'b1;
    run_txn(0, 1, 17'h00010, 32'h11223344, 4'b0100, 0, 0, 1, 1, 0, 32'h0);
    run_txn(1, 0, 17'h00020, 32'h0, 4'b0010, 3, 2, 1, 1, 0, 32'hA1B2C3D4);
    run_txn(1, 0, 17'h00030, 32'h0, 4'b0001, 0, 0, 1, 0, 0, 32'h0);
    run_txn(1, 1, 17'h00040, 32'h55AA55AA, 4'b1111, 1, 1, 1, 1, 1, 32'h01234567);
    run_txn(1, 0, 17'h00050, 32'h0, 4'b1001, 0, 0, 1, 1, 0, 32'hCAFEF00D);
    run_txn(0, 1, 17'h1FFFF, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 0, 32'h0);
    for (int n = 0; n < 40; n++) begin
      bit r;
      r = 1'($urandom % 2);
      run_txn(r, r ? ($urandom % 4 == 0) : 1'b1, 17'($urandom), $urandom, 4'($urandom),
              int'($urandom % 7), int'($urandom % 7), $urandom % 8 != 0, $urandom % 6 != 0,
              $urandom % 4 == 0, $urandom);
    end
    @(negedge clk);
    rd_i = 1'b1; addr_i = 17'h00123; be_i = 4'hF; tgt_wait = 1'b0;
    @(negedge clk);
    rd_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(waitreq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_wait", 32'(waitreq), 32'd0);
    chk("async_tgt", {tgt_rd, tgt_wr, tgt_be, tgt_addr}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tgt_rdv = 1'b1; tgt_rdata = 32'h87654321;
    @(negedge clk);
    tgt_rdv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_rdv", 32'(rdv), 32'd0);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
